// File: rtl/sysid_read_arbiter_if.sv
// Avalon-MM read-only master port used by each requester of the system-ID slave.
// The arbiter sees the slave side, the requesting master sees the master side.
interface sysid_read_arbiter_if;
    logic        read;
    logic        address;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output read,
        output address,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  read,
        input  address,
        output waitrequest,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/sysid_read_arbiter.sv
// Round-robin read arbiter sharing the combinational sysid control slave between two
// Avalon-MM masters; holds sid_address for ACCESS_CYCLES before capturing the data.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no read in progress; one granted request may be accepted
// ST_ACCESS | sid_address driven, counting down settle cycles to capture
module sysid_read_arbiter #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    sysid_read_arbiter_if.slave  m0,
    sysid_read_arbiter_if.slave  m1,
    output logic                 sid_address,
    input  logic [31:0]          sid_readdata,
    output logic                 busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Counter reloads with one less than the settle time so that terminal count
    // lands on the last ACCESS cycle.
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       rr_ptr;
    logic       owner;
    logic [3:0] cnt;
    logic       grant_valid;
    logic       grant_id;
    logic       accept;
    logic       cnt_done;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (m0.read && m1.read) begin
            grant_valid = 1'b1;
            grant_id    = rr_ptr;
        end else if (m0.read) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (m1.read) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign cnt_done = (cnt == 4'd0);
    assign accept   = (state == ST_IDLE) && grant_valid && !reset;

    // Waitrequest is combinational so a read can be accepted in the cycle it rises.
    assign m0.waitrequest = !(accept && (grant_id == 1'b0));
    assign m1.waitrequest = !(accept && (grant_id == 1'b1));
    assign busy           = (state == ST_ACCESS);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            cnt         <= 4'd0;
            sid_address <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sid_address <= grant_id ? m1.address : m0.address;
                owner       <= grant_id;
                cnt         <= CNT_LOAD;
                rr_ptr      <= ~grant_id;
            end else if ((state == ST_ACCESS) && !cnt_done) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Read data returns only to the owner; the other master's outputs are untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0.readdata      <= 32'd0;
            m0.readdatavalid <= 1'b0;
            m1.readdata      <= 32'd0;
            m1.readdatavalid <= 1'b0;
        end else begin
            m0.readdatavalid <= 1'b0;
            m1.readdatavalid <= 1'b0;
            if ((state == ST_ACCESS) && cnt_done) begin
                if (owner) begin
                    m1.readdata      <= sid_readdata;
                    m1.readdatavalid <= 1'b1;
                end else begin
                    m0.readdata      <= sid_readdata;
                    m0.readdatavalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sysid_read_arbiter.md
# sysid_read_arbiter

Shares the single-address system-ID control slave between two Avalon-MM read masters, e.g. the Nios II data master and a JTAG/debug master. Grants one read at a time, round-robin, using a registered access sequence with a programmable settle delay. Returns data to the winning master with a `readdatavalid` pulse. Sits between the masters' interconnect ports and the sysid `control_slave`, which is purely combinational: `address` in, `readdata` out.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 1: cycles `sid_address` is held before `sid_readdata` is sampled. Legal range 1..15.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `m0_read`  in  1  master 0 read request; held until accepted
- `m0_address`  in  1  master 0 word address (0 = ID, 1 = timestamp)
- `m0_waitrequest`  out  1  low only in the cycle master 0's read is accepted
- `m0_readdata`  out  32  master 0 read data; valid when `m0_readdatavalid` = 1
- `m0_readdatavalid`  out  1  one-cycle pulse per completed master 0 read
- `m1_read`, `m1_address`, `m1_waitrequest`, `m1_readdata`, `m1_readdatavalid`: same as m0, for master 1
- `sid_address`  out  1  address to the sysid slave
- `sid_readdata`  in  32  data from the sysid slave (combinational function of `sid_address`)
- `busy`  out  1  high while a read is in the ACCESS state

## Operation
- States:
  - IDLE: may accept one request.
  - ACCESS: counts settle cycles on `sid_address`.
- Arbitration in IDLE:
  - Exactly one `mX_read` high: grant X.
  - Both high: grant the master indicated by `rr_ptr`.
  - Neither high: no grant.
- `mX_waitrequest` = NOT(state == IDLE AND granted X AND NOT `reset`). It is combinational, so a waitrequest can fall in the same cycle its read rises.
- On accept (edge ending a granted IDLE cycle):
  - `sid_address` <= `mX_address`; `owner` <= X.
  - `cnt` <= `ACCESS_CYCLES` - 1; state -> ACCESS.
  - `rr_ptr` <= NOT X.
- In ACCESS:
  - If `cnt` != 0, decrement.
  - If `cnt` == 0: `mOwner_readdata` <= `sid_readdata`; `mOwner_readdatavalid` <= 1; state -> IDLE.
- `mX_readdatavalid` is a registered one-cycle pulse and is cleared on the next edge.
- The non-owner's `readdata` and `readdatavalid` are unchanged.
- `mX_readdata` holds its last captured value between reads.
- `sid_address` holds its last value when idle.
- `busy` = (state == ACCESS), decoded from a registered state.
- A read that is not yet accepted may not change its address; behaviour is undefined if it does, and there is no check.
- Writes are not supported. The slave is read-only, and masters must not issue writes through this block.

## Timing
- Reset values:
  - State IDLE; `rr_ptr` = 0 (master 0 favoured); `owner` = 0; `cnt` = 0.
  - `sid_address` = 0; both `readdata` = 0; both `readdatavalid` = 0; `busy` = 0.
  - Both `waitrequest` = 1 while `reset` is high.
- Latency, with accept in cycle T:
  - `busy` is high in cycles T+1 .. T+ACCESS_CYCLES.
  - `sid_address` is valid from T+1.
  - `readdatavalid` is high in cycle T+ACCESS_CYCLES+1.
- Back-to-back: the cycle carrying `readdatavalid` is an IDLE cycle, so a new accept is possible there. Peak throughput is one read per ACCESS_CYCLES+1 cycles.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, … from reset. Neither master waits more than one full access.
- Reset mid-ACCESS:
  - The transaction is dropped with no `readdatavalid`.
  - All registers return to reset values asynchronously.
  - A master must reissue its read after reset.
- A request arriving during ACCESS sees `waitrequest` = 1 until the next IDLE cycle.

## Test plan
Bench sysid model: address 0 returns 0x00000000; address 1 returns 0x58D6E59B.
- Reset, then single m0 read of address 1 with ACCESS_CYCLES = 1: `m0_waitrequest` is low in the request cycle T; `busy` is high in T+1; `m0_readdatavalid` is high in T+2 with `m0_readdata` = 0x58D6E59B. m1 outputs stay at 0.
- m0 and m1 raise `read` in the same cycle (m0 address 0, m1 address 1), with both held until accepted: m0 is granted first and returns 0x00000000; m1 is accepted in m0's `readdatavalid` cycle and returns 0x58D6E59B two cycles later.
- Both masters request continuously for 8 reads with ACCESS_CYCLES = 3: grant order is m0, m1, m0, m1, …; each `readdatavalid` arrives 4 cycles after its accept, with no gaps between accesses.
- Assert `reset` in the middle cycle of a read with ACCESS_CYCLES = 3: no `readdatavalid` is issued. After release, all outputs are at reset values and a reissued m1 read completes normally.
- m1 read in flight while m0 raises `read`: `m0_waitrequest` stays 1 through ACCESS. m0 is accepted in m1's `readdatavalid` cycle, and `m1_readdata` keeps its value after m0 completes.
